int_issue_queue: RTL and testbench

INT_ISSUE_QUEUE -- requirements
Module: int_issue_queue

---
 rtl/int_issue_queue.sv | 205 ++++++++++++++++++++
 tb/tb_int_issue_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_issue_queue.sv
// ---------------------------------------------------------------------------
// int_issue_queue -- age-ordered integer issue queue with tag wakeup and
// branch flush.
//
// Entries live in a compacting array: slot 0 is the oldest and occupied
// slots are contiguous from 0. Each cycle the oldest entry whose op0/op1 are
// both ready (in registered state) is issued through a one-cycle output
// register, and the entries above it slide down by one.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   en                  global enable; gates enqueue and issue
//   IN_valid/OUT_ready  enqueue handshake; OUT_ready = registered count < DEPTH
//   IN_operands/opReady/opTag/opcode/tagDst/nmDst/sqN   enqueued micro-op
//   IN_resultValid/resultTag/result                     wakeup broadcast
//   IN_branchTaken/branchSqN                            flush younger entries
//   IN_wbStall          downstream cannot accept; blocks issue only
//   OUT_valid/operands/opcode/tagDst/nmDst/sqN          issued micro-op
// ---------------------------------------------------------------------------
package int_issue_queue_pkg;
   typedef enum logic [5:0] {
      INT_ADD = 6'd0, INT_SUB, INT_AND, INT_OR, INT_XOR, INT_SLL, INT_SRL, INT_SLT
   } OPCode_INT;

   typedef struct packed {
      logic [31:0] op0;
      logic [31:0] op1;
      logic [31:0] op2;
      logic        rdy0;
      logic        rdy1;
      logic [5:0]  tag0;
      logic [5:0]  tag1;
      OPCode_INT   opc;
      logic [5:0]  tag_dst;
      logic [4:0]  nm_dst;
      logic [5:0]  sqn;
   } iq_entry_t;
endpackage

module int_issue_queue
   import int_issue_queue_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        IN_valid,
   output logic        OUT_ready,
   input  logic [31:0] IN_operands [2:0],
   input  logic [1:0]  IN_opReady,
   input  logic [5:0]  IN_opTag [1:0],
   input  OPCode_INT   IN_opcode,
   input  logic [5:0]  IN_tagDst,
   input  logic [4:0]  IN_nmDst,
   input  logic [5:0]  IN_sqN,
   input  logic        IN_resultValid,
   input  logic [5:0]  IN_resultTag,
   input  logic [31:0] IN_result,
   input  logic        IN_branchTaken,
   input  logic [5:0]  IN_branchSqN,
   input  logic        IN_wbStall,
   output logic        OUT_valid,
   output logic [31:0] OUT_operands [2:0],
   output OPCode_INT   OUT_opcode,
   output logic [5:0]  OUT_tagDst,
   output logic [4:0]  OUT_nmDst,
   output logic [5:0]  OUT_sqN
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // a is younger than b when (a - b) mod 64, read as signed, is positive.
   function automatic logic younger(input logic [5:0] a, input logic [5:0] b);
      logic [5:0] d;
      d = a - b;
      return (d != 6'd0) && !d[5];
   endfunction

   iq_entry_t        ent_reg [DEPTH];
   iq_entry_t        ent_next [DEPTH];
   iq_entry_t        wake [DEPTH];
   iq_entry_t        new_ent;
   logic [CW-1:0]    count_reg, count_next, surv;
   logic [DEPTH-1:0] valid, kill;
   logic [IW-1:0]    issue_sel;
   logic             issue_cand, issue_fire, do_enq;

   assign OUT_ready = (count_reg < CW'(DEPTH));

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         assign valid[gi] = (count_reg > CW'(gi));
         assign kill[gi]  = IN_branchTaken && younger(ent_reg[gi].sqn, IN_branchSqN);
      end
   endgenerate

   // Wakeup on stored entries; takes effect in the next registered state.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         wake[i] = ent_reg[i];
         if (IN_resultValid && !ent_reg[i].rdy0 && ent_reg[i].tag0 == IN_resultTag) begin
            wake[i].op0  = IN_result;
            wake[i].rdy0 = 1'b1;
         end
         if (IN_resultValid && !ent_reg[i].rdy1 && ent_reg[i].tag1 == IN_resultTag) begin
            wake[i].op1  = IN_result;
            wake[i].rdy1 = 1'b1;
         end
      end
   end

   // Incoming entry, with the same wakeup comparison applied as a bypass.
   always_comb begin
      new_ent         = '0;
      new_ent.op0     = IN_operands[0];
      new_ent.op1     = IN_operands[1];
      new_ent.op2     = IN_operands[2];
      new_ent.rdy0    = IN_opReady[0];
      new_ent.rdy1    = IN_opReady[1];
      new_ent.tag0    = IN_opTag[0];
      new_ent.tag1    = IN_opTag[1];
      new_ent.opc     = IN_opcode;
      new_ent.tag_dst = IN_tagDst;
      new_ent.nm_dst  = IN_nmDst;
      new_ent.sqn     = IN_sqN;
      if (IN_resultValid && !IN_opReady[0] && IN_opTag[0] == IN_resultTag) begin
         new_ent.op0  = IN_result;
         new_ent.rdy0 = 1'b1;
      end
      if (IN_resultValid && !IN_opReady[1] && IN_opTag[1] == IN_resultTag) begin
         new_ent.op1  = IN_result;
         new_ent.rdy1 = 1'b1;
      end
   end

   // Oldest ready, non-flushed entry wins; scanning downward leaves the
   // lowest index selected.
   always_comb begin
      issue_sel  = '0;
      issue_cand = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (valid[i] && ent_reg[i].rdy0 && ent_reg[i].rdy1 && !kill[i]) begin
            issue_sel  = IW'(i);
            issue_cand = 1'b1;
         end
      end
      issue_fire = issue_cand && en && !IN_wbStall;
   end

   assign do_enq = IN_valid && OUT_ready && en &&
                   !(IN_branchTaken && younger(IN_sqN, IN_branchSqN));

   // Removal, compaction, then enqueue. Because slots are in program order,
   // flushed entries always form a tail, so after closing the gap left by the
   // issued entry the survivors are still contiguous from slot 0.
   always_comb begin
      surv = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_next[i] = wake[i];
         if (valid[i] && !kill[i])
            surv = surv + CW'(1);
      end
      for (int j = 0; j < DEPTH - 1; j++) begin
         if (issue_fire && IW'(j) >= issue_sel)
            ent_next[j] = wake[j + 1];
      end
      if (issue_fire)
         surv = surv - CW'(1);
      count_next = surv;
      if (do_enq) begin
         ent_next[surv[IW-1:0]] = new_ent;
         count_next = surv + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg <= '0;
         for (int i = 0; i < DEPTH; i++)
            ent_reg[i] <= '0;
         OUT_valid <= 1'b0;
         for (int k = 0; k < 3; k++)
            OUT_operands[k] <= '0;
         OUT_opcode <= INT_ADD;
         OUT_tagDst <= '0;
         OUT_nmDst  <= '0;
         OUT_sqN    <= '0;
      end else begin
         count_reg <= count_next;
         ent_reg   <= ent_next;
         OUT_valid <= issue_fire;
         if (issue_fire) begin
            OUT_operands[0] <= ent_reg[issue_sel].op0;
            OUT_operands[1] <= ent_reg[issue_sel].op1;
            OUT_operands[2] <= ent_reg[issue_sel].op2;
            OUT_opcode      <= ent_reg[issue_sel].opc;
            OUT_tagDst      <= ent_reg[issue_sel].tag_dst;
            OUT_nmDst       <= ent_reg[issue_sel].nm_dst;
            OUT_sqN         <= ent_reg[issue_sel].sqn;
         end
      end
   end
endmodule

// File: tb/tb_int_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_int_issue_queue -- self-checking bench for int_issue_queue.
// Every enqueued micro-op expected to issue is pushed to a scoreboard when it
// is driven; every OUT_valid cycle pops and compares the oldest expectation.
// ---------------------------------------------------------------------------
module tb_int_issue_queue;
   import int_issue_queue_pkg::*;

   typedef struct {
      logic [5:0]  sqn;
      logic [31:0] op0;
      logic [31:0] op1;
      logic [31:0] op2;
      OPCode_INT   opc;
      logic [5:0]  tdst;
      logic [4:0]  nm;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, en, IN_valid, OUT_ready;
   logic [31:0] IN_operands [2:0];
   logic [1:0]  IN_opReady;
   logic [5:0]  IN_opTag [1:0];
   OPCode_INT   IN_opcode;
   logic [5:0]  IN_tagDst, IN_sqN, IN_resultTag, IN_branchSqN;
   logic [4:0]  IN_nmDst;
   logic        IN_resultValid, IN_branchTaken, IN_wbStall;
   logic [31:0] IN_result;
   logic        OUT_valid;
   logic [31:0] OUT_operands [2:0];
   OPCode_INT   OUT_opcode;
   logic [5:0]  OUT_tagDst, OUT_sqN;
   logic [4:0]  OUT_nmDst;

   int   total = 0;
   int   bad = 0;
   vec_t sb[$];
   vec_t vecs[6];

   always #5 clk = ~clk;

   int_issue_queue #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .en(en), .IN_valid(IN_valid), .OUT_ready(OUT_ready),
      .IN_operands(IN_operands), .IN_opReady(IN_opReady), .IN_opTag(IN_opTag),
      .IN_opcode(IN_opcode), .IN_tagDst(IN_tagDst), .IN_nmDst(IN_nmDst),
      .IN_sqN(IN_sqN), .IN_resultValid(IN_resultValid), .IN_resultTag(IN_resultTag),
      .IN_result(IN_result), .IN_branchTaken(IN_branchTaken),
      .IN_branchSqN(IN_branchSqN), .IN_wbStall(IN_wbStall), .OUT_valid(OUT_valid),
      .OUT_operands(OUT_operands), .OUT_opcode(OUT_opcode), .OUT_tagDst(OUT_tagDst),
      .OUT_nmDst(OUT_nmDst), .OUT_sqN(OUT_sqN)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic enq(input logic [5:0] sqn, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [1:0] rdy, input logic [5:0] t0,
                      input logic [5:0] t1, input OPCode_INT opc, input logic [5:0] td,
                      input logic [4:0] nm);
      IN_valid = 1'b1;
      IN_sqN = sqn;
      IN_operands[0] = a;
      IN_operands[1] = b;
      IN_operands[2] = c;
      IN_opReady = rdy;
      IN_opTag[0] = t0;
      IN_opTag[1] = t1;
      IN_opcode = opc;
      IN_tagDst = td;
      IN_nmDst = nm;
   endtask

   task automatic push(input logic [5:0] sqn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input OPCode_INT opc, input logic [5:0] td,
                       input logic [4:0] nm);
      vec_t e;
      e.sqn = sqn; e.op0 = a; e.op1 = b; e.op2 = c; e.opc = opc; e.tdst = td; e.nm = nm;
      sb.push_back(e);
   endtask

   // Advance one clock, sample outputs 1 time unit after the edge, compare any
   // issued micro-op against the scoreboard, then clear one-shot inputs.
   task automatic step();
      vec_t e;
      @(posedge clk);
      #1;
      if (OUT_valid) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_issue got sqN=%0d want no issue", OUT_sqN);
         end else begin
            e = sb.pop_front();
            if (OUT_sqN !== e.sqn || OUT_operands[0] !== e.op0 || OUT_operands[1] !== e.op1 ||
                OUT_operands[2] !== e.op2 || OUT_opcode !== e.opc || OUT_tagDst !== e.tdst ||
                OUT_nmDst !== e.nm) begin
               bad++;
               $display("FAIL issue_fields got sqN=%0d op=%h/%h/%h opc=%0d td=%0d nm=%0d want sqN=%0d op=%h/%h/%h opc=%0d td=%0d nm=%0d",
                        OUT_sqN, OUT_operands[0], OUT_operands[1], OUT_operands[2], OUT_opcode,
                        OUT_tagDst, OUT_nmDst, e.sqn, e.op0, e.op1, e.op2, e.opc, e.tdst, e.nm);
            end else begin
               $display("issue sqN=%0d op0=%h op1=%h op2=%h ok", OUT_sqN, OUT_operands[0],
                        OUT_operands[1], OUT_operands[2]);
            end
         end
      end
      IN_valid = 1'b0;
      IN_resultValid = 1'b0;
      IN_branchTaken = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 20 && sb.size() != 0; k++)
         step();
      chk(name, 32'(sb.size()), 0);
      step();
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{6'd40, 32'h1, 32'h2, 32'h3, INT_ADD, 6'd1, 5'd1};
      vecs[1] = '{6'd41, 32'hFFFF_FFFF, 32'h0, 32'h10, INT_SUB, 6'd2, 5'd2};
      vecs[2] = '{6'd42, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0, INT_AND, 6'd3, 5'd31};
      vecs[3] = '{6'd43, 32'h8000_0000, 32'h7FFF_FFFF, 32'hDEAD, INT_OR, 6'd63, 5'd0};
      vecs[4] = '{6'd44, 32'h1234_5678, 32'h9ABC_DEF0, 32'hBEEF, INT_XOR, 6'd20, 5'd17};
      vecs[5] = '{6'd45, 32'h0, 32'h1F, 32'hFFFF, INT_SLT, 6'd33, 5'd9};

      rst = 1'b0; en = 1'b1; IN_valid = 1'b0; IN_opReady = 2'b00;
      IN_operands[0] = '0; IN_operands[1] = '0; IN_operands[2] = '0;
      IN_opTag[0] = '0; IN_opTag[1] = '0; IN_opcode = INT_ADD;
      IN_tagDst = '0; IN_nmDst = '0; IN_sqN = '0; IN_resultValid = 1'b0;
      IN_resultTag = '0; IN_result = '0; IN_branchTaken = 1'b0; IN_branchSqN = '0;
      IN_wbStall = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(OUT_valid), 0);
      chk("rst_out_sqn", 32'(OUT_sqN), 0);
      chk("rst_out_op0", OUT_operands[0], 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("ready_after_rst", 32'(OUT_ready), 1);

      // Back-to-back ready entries from the vector table.
      for (int i = 0; i < 6; i++) begin
         enq(vecs[i].sqn, vecs[i].op0, vecs[i].op1, vecs[i].op2, 2'b11, 6'd0, 6'd0,
             vecs[i].opc, vecs[i].tdst, vecs[i].nm);
         push(vecs[i].sqn, vecs[i].op0, vecs[i].op1, vecs[i].op2, vecs[i].opc,
              vecs[i].tdst, vecs[i].nm);
         step();
      end
      drain("table_drain");

      // Single ready ADD.
      enq(6'd3, 32'd5, 32'd7, 32'd0, 2'b11, 6'd0, 6'd0, INT_ADD, 6'd8, 5'd4);
      push(6'd3, 32'd5, 32'd7, 32'd0, INT_ADD, 6'd8, 5'd4);
      step();
      drain("add_drain");

      // op1 waits for tag 9, broadcast two cycles after enqueue.
      enq(6'd4, 32'h11, 32'hDEAD, 32'h22, 2'b01, 6'd0, 6'd9, INT_SUB, 6'd12, 5'd3);
      step();
      step();
      chk("wait_no_issue", 32'(OUT_valid), 0);
      IN_resultValid = 1'b1; IN_resultTag = 6'd9; IN_result = 32'h1234;
      push(6'd4, 32'h11, 32'h1234, 32'h22, INT_SUB, 6'd12, 5'd3);
      step();
      chk("wake_not_early", 32'(OUT_valid), 0);
      step();
      chk("wake_issue", 32'(OUT_valid), 1);
      chk("wake_op1", OUT_operands[1], 32'h1234);
      drain("wake_drain");

      // Enqueue-cycle bypass of a wakeup for tag 4 on op0.
      enq(6'd5, 32'h0, 32'h77, 32'h0, 2'b10, 6'd4, 6'd0, INT_XOR, 6'd13, 5'd6);
      IN_resultValid = 1'b1; IN_resultTag = 6'd4; IN_result = 32'hAA;
      push(6'd5, 32'hAA, 32'h77, 32'h0, INT_XOR, 6'd13, 5'd6);
      step();
      chk("bypass_not_early", 32'(OUT_valid), 0);
      step();
      chk("bypass_issue", 32'(OUT_valid), 1);
      chk("bypass_op0", OUT_operands[0], 32'hAA);
      drain("bypass_drain");

      // Fill under stall, ignored fifth request, then in-order drain.
      IN_wbStall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         enq(6'(10 + k), 32'(100 + k), 32'(200 + k), 32'(k), 2'b11, 6'd0, 6'd0,
             INT_ADD, 6'(k), 5'(k));
         push(6'(10 + k), 32'(100 + k), 32'(200 + k), 32'(k), INT_ADD, 6'(k), 5'(k));
         step();
      end
      chk("full_not_ready", 32'(OUT_ready), 0);
      enq(6'd14, 32'h999, 32'h999, 32'h0, 2'b11, 6'd0, 6'd0, INT_ADD, 6'd0, 5'd0);
      step();
      chk("full_still_not_ready", 32'(OUT_ready), 0);
      IN_wbStall = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("one_per_cycle", 32'(OUT_valid), 1);
      end
      step();
      chk("fifth_dropped", 32'(OUT_valid), 0);
      chk("fill_sb_empty", 32'(sb.size()), 0);

      // Flush across sqN wrap: 0 and 1 are younger than 63.
      IN_wbStall = 1'b1;
      enq(6'd62, 32'h62, 32'h1, 32'h0, 2'b11, 6'd0, 6'd0, INT_OR, 6'd5, 5'd5); step();
      enq(6'd63, 32'h63, 32'h1, 32'h0, 2'b11, 6'd0, 6'd0, INT_OR, 6'd6, 5'd6); step();
      enq(6'd0,  32'h00, 32'h1, 32'h0, 2'b11, 6'd0, 6'd0, INT_OR, 6'd7, 5'd7); step();
      enq(6'd1,  32'h01, 32'h1, 32'h0, 2'b11, 6'd0, 6'd0, INT_OR, 6'd8, 5'd8); step();
      push(6'd62, 32'h62, 32'h1, 32'h0, INT_OR, 6'd5, 5'd5);
      push(6'd63, 32'h63, 32'h1, 32'h0, INT_OR, 6'd6, 5'd6);
      IN_branchTaken = 1'b1; IN_branchSqN = 6'd63;
      step();
      chk("flush_ready", 32'(OUT_ready), 1);
      IN_wbStall = 1'b0;
      drain("flush_drain");

      // en=0 blocks enqueue.
      en = 1'b0;
      enq(6'd20, 32'h5, 32'h5, 32'h5, 2'b11, 6'd0, 6'd0, INT_ADD, 6'd0, 5'd0);
      step();
      step();
      en = 1'b1;
      step();
      step();
      chk("en0_no_issue", 32'(OUT_valid), 0);

      // Asynchronous reset with entries held and an issue pending.
      IN_wbStall = 1'b1;
      enq(6'd30, 32'h30, 32'h0, 32'h0, 2'b11, 6'd0, 6'd0, INT_SLL, 6'd1, 5'd1); step();
      enq(6'd31, 32'h31, 32'h0, 32'h0, 2'b11, 6'd0, 6'd0, INT_SLL, 6'd2, 5'd2); step();
      enq(6'd32, 32'h32, 32'h0, 32'h0, 2'b11, 6'd0, 6'd0, INT_SLL, 6'd3, 5'd3); step();
      push(6'd30, 32'h30, 32'h0, 32'h0, INT_SLL, 6'd1, 5'd1);
      IN_wbStall = 1'b0;
      step();
      chk("pre_rst_issue", 32'(OUT_valid), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_valid", 32'(OUT_valid), 0);
      chk("async_rst_sqn", 32'(OUT_sqN), 0);
      @(negedge clk);
      rst = 1'b1;
      step();
      step();
      chk("post_rst_idle", 32'(OUT_valid), 0);
      chk("post_rst_ready", 32'(OUT_ready), 1);
      chk("final_sb_empty", 32'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
